// File: rtl/encoder_8x3_pkg.sv
// Shared constants and types for the 8-to-3 priority encoder.
// The sub-module and the top level both import this package.
package encoder_8x3_pkg;

    localparam int NUM_IN = 8;
    localparam int CODE_W = 3;
    // Wide enough to count all eight request lines (0..8)
    localparam int CNT_W  = 4;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [CNT_W-1:0]  cnt_t;

endpackage : encoder_8x3_pkg

// File: rtl/encoder_8x3_prio_comb.sv
// Combinational core of the encoder.
// Produces the highest-index code (d7 wins), an any-active flag and a multiple-active flag.
module encoder_8x3_prio_comb
    import encoder_8x3_pkg::*;
(
    input  logic [NUM_IN-1:0] d_i,
    output code_t             code_o,
    output logic              any_o,
    output logic              multi_o
);

    cnt_t pop_cnt;

    // The chain is ordered from d7 down to d0, so the highest active line decides the code
    always_comb begin
        code_o = '0;
        if (d_i[7])      code_o = 3'd7;
        else if (d_i[6]) code_o = 3'd6;
        else if (d_i[5]) code_o = 3'd5;
        else if (d_i[4]) code_o = 3'd4;
        else if (d_i[3]) code_o = 3'd3;
        else if (d_i[2]) code_o = 3'd2;
        else if (d_i[1]) code_o = 3'd1;
        else             code_o = 3'd0;
    end

    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            pop_cnt = pop_cnt + {{(CNT_W-1){1'b0}}, d_i[i]};
        end
    end

    assign any_o   = (pop_cnt != '0);
    assign multi_o = (pop_cnt >= cnt_t'(2));

endmodule : encoder_8x3_prio_comb

// File: rtl/encoder_8x3_behavioral_using_if_else.sv
// Registered 8-to-3 priority encoder with valid and multi flags.
// Optionally holds the last valid code while no request line is active.
module encoder_8x3_behavioral_using_if_else
    import encoder_8x3_pkg::*;
#(
    parameter bit HOLD_ON_IDLE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d0,
    input  logic d1,
    input  logic d2,
    input  logic d3,
    input  logic d4,
    input  logic d5,
    input  logic d6,
    input  logic d7,
    output logic a0,
    output logic a1,
    output logic a2,
    output logic valid,
    output logic multi
);

    logic [NUM_IN-1:0] d_vec;
    code_t             comb_code;
    logic              comb_any;
    logic              comb_multi;

    code_t code_q, code_d;
    logic  valid_q, valid_d;
    logic  multi_q, multi_d;

    assign d_vec = {d7, d6, d5, d4, d3, d2, d1, d0};

    encoder_8x3_prio_comb u_prio (
        .d_i     (d_vec),
        .code_o  (comb_code),
        .any_o   (comb_any),
        .multi_o (comb_multi)
    );

    always_comb begin
        code_d  = '0;
        valid_d = comb_any;
        multi_d = comb_multi;
        if (comb_any) begin
            code_d = comb_code;
        end else if (HOLD_ON_IDLE) begin
            code_d = code_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code_q  <= '0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            code_q  <= code_d;
            valid_q <= valid_d;
            multi_q <= multi_d;
        end
    end

    assign a0    = code_q[0];
    assign a1    = code_q[1];
    assign a2    = code_q[2];
    assign valid = valid_q;
    assign multi = multi_q;

endmodule : encoder_8x3_behavioral_using_if_else

// File: tb/tb_encoder_8x3_behavioral_using_if_else.sv
// Directed bench: one encoder with HOLD_ON_IDLE=0 and one with HOLD_ON_IDLE=1 share the inputs.
// Observed values are packed as {a2,a1,a0,valid,multi}.
module tb_encoder_8x3_behavioral_using_if_else;

    logic       clk;
    logic       rst;
    logic [7:0] d;

    logic a0_n, a1_n, a2_n, valid_n, multi_n;
    logic a0_h, a1_h, a2_h, valid_h, multi_h;

    int vec_cnt;
    int err_cnt;

    encoder_8x3_behavioral_using_if_else #(.HOLD_ON_IDLE(1'b0)) dut_nohold (
        .clk(clk), .rst(rst),
        .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
        .d4(d[4]), .d5(d[5]), .d6(d[6]), .d7(d[7]),
        .a0(a0_n), .a1(a1_n), .a2(a2_n), .valid(valid_n), .multi(multi_n)
    );

    encoder_8x3_behavioral_using_if_else #(.HOLD_ON_IDLE(1'b1)) dut_hold (
        .clk(clk), .rst(rst),
        .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
        .d4(d[4]), .d5(d[5]), .d6(d[6]), .d7(d[7]),
        .a0(a0_h), .a1(a1_h), .a2(a2_h), .valid(valid_h), .multi(multi_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] obs_nohold();
        return {a2_n, a1_n, a0_n, valid_n, multi_n};
    endfunction

    function automatic logic [4:0] obs_hold();
        return {a2_h, a1_h, a0_h, valid_h, multi_h};
    endfunction

    task automatic check(input string tag, input logic [4:0] observed, input logic [4:0] expected);
        vec_cnt++;
        assert (observed === expected)
        else begin
            err_cnt++;
            $error("FAIL %s: observed a/v/m=%b required=%b", tag, observed, expected);
        end
        $display("vec %0d %s: observed=%b expected=%b", vec_cnt, tag, observed, expected);
    endtask

    // Drive d at the falling edge, sample both DUTs 1 time unit after the next rising edge
    task automatic step(input string tag, input logic [7:0] din,
                        input logic [4:0] exp_n, input logic [4:0] exp_h);
        @(negedge clk);
        d = din;
        @(posedge clk);
        #1;
        check({tag, "/nohold"}, obs_nohold(), exp_n);
        check({tag, "/hold"},   obs_hold(),   exp_h);
    endtask

    logic [4:0] prev_exp;
    logic [4:0] walk_exp;

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst = 1'b1;
        d   = 8'h00;

        // Case 1: reset state, then release with all inputs low
        #3;
        check("rst_nohold", obs_nohold(), 5'b000_0_0);
        check("rst_hold",   obs_hold(),   5'b000_0_0);
        @(negedge clk);
        rst = 1'b0;
        step("release_zero", 8'h00, 5'b000_0_0, 5'b000_0_0);

        // Case 2: single active lines
        step("d3_only", 8'h08, 5'b011_1_0, 5'b011_1_0);
        step("d1_only", 8'h02, 5'b001_1_0, 5'b001_1_0);

        // Case 3: d0 alone versus nothing active
        step("d0_only", 8'h01, 5'b000_1_0, 5'b000_1_0);
        step("all_zero", 8'h00, 5'b000_0_0, 5'b000_0_0);

        // Case 4: several active lines
        step("d1_d2_d5", 8'h26, 5'b101_1_1, 5'b101_1_1);
        step("all_ones", 8'hFF, 5'b111_1_1, 5'b111_1_1);
        step("d4_d0",    8'h11, 5'b100_1_1, 5'b100_1_1);

        // Case 5: hold behaviour and asynchronous reset between edges
        step("d6_only", 8'h40, 5'b110_1_0, 5'b110_1_0);
        step("idle_hold", 8'h00, 5'b000_0_0, 5'b110_0_0);
        step("idle_hold2", 8'h00, 5'b000_0_0, 5'b110_0_0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_hold",   obs_hold(),   5'b000_0_0);
        check("async_rst_nohold", obs_nohold(), 5'b000_0_0);
        @(posedge clk);
        #1;
        check("rst_held_hold", obs_hold(), 5'b000_0_0);
        @(negedge clk);
        rst = 1'b0;
        step("first_after_rst", 8'h80, 5'b111_1_0, 5'b111_1_0);

        // Case 6: one-hot walk; output must not move before the sampling edge
        prev_exp = 5'b111_1_0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            d = 8'h01 << i;
            #1;
            check($sformatf("walk%0d_pre", i), obs_nohold(), prev_exp);
            walk_exp = {3'(i), 1'b1, 1'b0};
            @(posedge clk);
            #1;
            check($sformatf("walk%0d_nohold", i), obs_nohold(), walk_exp);
            check($sformatf("walk%0d_hold", i),   obs_hold(),   walk_exp);
            prev_exp = walk_exp;
        end
        step("walk_idle", 8'h00, 5'b000_0_0, 5'b111_0_0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, required finish before 20000");
        $fatal(1, "timeout");
    end

endmodule : tb_encoder_8x3_behavioral_using_if_else
